// File: rtl/cpu_datapath_regs_if.sv
// Synchronous main-memory bus between the datapath register stage and memory.
interface cpu_datapath_regs_if #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 16
);
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport slave (
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/cpu_datapath_regs.sv
// Register-transfer stage executing the CU's rising-edge micro-ops on PC/MAR/MBR/IR/BR.
// Optional DP_TRACE_EN adds trace_valid/trace_pc reporting each instruction fetch address.
module cpu_datapath_regs #(
   parameter int unsigned      DATA_W   = 16,
   parameter int unsigned      ADDR_W   = 8,
   parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [15:0]         ctrl,
   input  logic [DATA_W-1:0]   acc_value,
   cpu_datapath_regs_if.master mem,
   output logic [7:0]          ir,
   output logic [DATA_W-1:0]   br,
   output logic [ADDR_W-1:0]   pc
`ifdef DP_TRACE_EN
   ,
   output logic                trace_valid,
   output logic [ADDR_W-1:0]   trace_pc
`endif
);

   localparam int unsigned UOP_W  = 9;
   localparam int unsigned IR_W   = 8;
   // Micro-op positions within ctrl[11:3]
   localparam int unsigned U_INC  = 0;
   localparam int unsigned U_JMP  = 1;
   localparam int unsigned U_MPC  = 2;
   localparam int unsigned U_MMB  = 3;
   localparam int unsigned U_RD   = 4;
   localparam int unsigned U_WR   = 5;
   localparam int unsigned U_IR   = 6;
   localparam int unsigned U_BR   = 7;
   localparam int unsigned U_ACC  = 8;

   logic [UOP_W-1:0]  uop;
   logic [UOP_W-1:0]  fire;
   logic              rd_fire;
   logic              wr_fire;

   logic [UOP_W-1:0]  prev_q,  prev_d;
   logic [ADDR_W-1:0] pc_q,    pc_d;
   logic [ADDR_W-1:0] mar_q,   mar_d;
   logic [DATA_W-1:0] mbr_q,   mbr_d;
   logic [IR_W-1:0]   ir_q,    ir_d;
   logic [DATA_W-1:0] br_q,    br_d;
   logic              pend_q,  pend_d;
`ifdef DP_TRACE_EN
   logic              tvld_q,  tvld_d;
   logic [ADDR_W-1:0] tpc_q,   tpc_d;
`endif

   // Sequencing and ALU-op fields belong to other blocks
   logic unused_ctrl;
   assign unused_ctrl = ^{ctrl[2:0], ctrl[15:12]};

   assign uop = ctrl[11:3];

   // Next-state: each micro-op acts once on its rising edge, sourcing pre-edge values
   always_comb begin
      fire    = uop & ~prev_q;
      wr_fire = fire[U_WR];
      rd_fire = fire[U_RD] & ~fire[U_WR];

      prev_d  = uop;
      pc_d    = pc_q;
      mar_d   = mar_q;
      mbr_d   = mbr_q;
      ir_d    = ir_q;
      br_d    = br_q;
      pend_d  = rd_fire;
`ifdef DP_TRACE_EN
      tvld_d  = fire[U_IR];
      tpc_d   = tpc_q;
`endif

      if (fire[U_JMP])      pc_d = mbr_q[ADDR_W-1:0];
      else if (fire[U_INC]) pc_d = pc_q + ADDR_W'(1);

      if (fire[U_MMB])      mar_d = mbr_q[ADDR_W-1:0];
      else if (fire[U_MPC]) mar_d = pc_q;

      // ACC load wins; an in-flight read's data is simply dropped
      if (fire[U_ACC])      mbr_d = acc_value;
      else if (pend_q)      mbr_d = mem.mem_rdata;

      if (fire[U_IR])       ir_d = mbr_q[DATA_W-1:DATA_W-IR_W];
      if (fire[U_BR])       br_d = mbr_q;
`ifdef DP_TRACE_EN
      if (fire[U_IR])       tpc_d = mar_q;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q <= '0;
         pc_q   <= PC_RESET;
         mar_q  <= '0;
         mbr_q  <= '0;
         ir_q   <= '0;
         br_q   <= '0;
         pend_q <= 1'b0;
`ifdef DP_TRACE_EN
         tvld_q <= 1'b0;
         tpc_q  <= '0;
`endif
      end else begin
         prev_q <= prev_d;
         pc_q   <= pc_d;
         mar_q  <= mar_d;
         mbr_q  <= mbr_d;
         ir_q   <= ir_d;
         br_q   <= br_d;
         pend_q <= pend_d;
`ifdef DP_TRACE_EN
         tvld_q <= tvld_d;
         tpc_q  <= tpc_d;
`endif
      end
   end

   // Strobes are combinational from the fire cycle so the access lines up with the edge
   assign mem.mem_en    = rd_fire | wr_fire;
   assign mem.mem_we    = wr_fire;
   assign mem.mem_addr  = mar_q;
   assign mem.mem_wdata = mbr_q;

   assign ir = ir_q;
   assign br = br_q;
   assign pc = pc_q;
`ifdef DP_TRACE_EN
   assign trace_valid = tvld_q;
   assign trace_pc    = tpc_q;
`endif

endmodule

// File: tb/tb_cpu_datapath_regs.sv
// Directed self-checking bench for cpu_datapath_regs with a synchronous memory model.
module tb_cpu_datapath_regs;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] ctrl;
   logic [15:0] acc_value;
   logic [7:0]  ir;
   logic [15:0] br;
   logic [7:0]  pc;
`ifdef DP_TRACE_EN
   logic        trace_valid;
   logic [7:0]  trace_pc;
   int          trc_cnt = 0;
   logic [7:0]  trc_last = '0;
`endif

   cpu_datapath_regs_if #(.ADDR_W(8), .DATA_W(16)) bus ();

   cpu_datapath_regs #(.DATA_W(16), .ADDR_W(8), .PC_RESET(8'h00)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ctrl      (ctrl),
      .acc_value (acc_value),
      .mem       (bus),
      .ir        (ir),
      .br        (br),
      .pc        (pc)
`ifdef DP_TRACE_EN
      ,
      .trace_valid (trace_valid),
      .trace_pc    (trace_pc)
`endif
   );

   always #5 clk = ~clk;

   logic [15:0] mem_arr [256];
   int          en_cnt = 0;
   int          rd_cnt = 0;
   int          wr_cnt = 0;
   logic [7:0]  last_raddr = '0;
   logic [7:0]  last_waddr = '0;
   logic [15:0] last_wdata = '0;
   int          n_tests = 0;
   int          n_fail  = 0;

   // Synchronous memory: read data valid the cycle after the strobe
   always @(posedge clk) begin
      if (bus.mem_en) begin
         en_cnt = en_cnt + 1;
         if (bus.mem_we) begin
            wr_cnt = wr_cnt + 1;
            last_waddr = bus.mem_addr;
            last_wdata = bus.mem_wdata;
            mem_arr[bus.mem_addr] = bus.mem_wdata;
         end else begin
            rd_cnt = rd_cnt + 1;
            last_raddr = bus.mem_addr;
            bus.mem_rdata <= mem_arr[bus.mem_addr];
         end
      end
`ifdef DP_TRACE_EN
      if (trace_valid) begin
         trc_cnt  = trc_cnt + 1;
         trc_last = trace_pc;
      end
`endif
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One control word held for two cycles
   task automatic cw(input logic [15:0] w);
      ctrl = w;
      repeat (2) @(negedge clk);
   endtask

   // One control word held for a single cycle
   task automatic cyc(input logic [15:0] w);
      ctrl = w;
      @(negedge clk);
   endtask

   int en_snap;

   initial begin
      for (int i = 0; i < 256; i++) mem_arr[i] = 16'h0000;
      mem_arr[8'h00] = 16'h0305;
      mem_arr[8'h20] = 16'h1234;
      mem_arr[8'h2A] = 16'h7777;
      bus.mem_rdata = 16'h0000;
      rst_n = 1'b0;
      ctrl = 16'h0000;
      acc_value = 16'h0000;
      repeat (2) @(negedge clk);

      check("rst_pc",    32'(pc), 32'h00);
      check("rst_mar",   32'(bus.mem_addr), 32'h00);
      check("rst_mbr",   32'(bus.mem_wdata), 32'h0000);
      check("rst_ir",    32'(ir), 32'h00);
      check("rst_br",    32'(br), 32'h0000);
      check("rst_en",    32'(bus.mem_en), 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // Fetch
      cw(16'h0020);
      cw(16'h0080);
      check("fetch_mbr", 32'(bus.mem_wdata), 32'h0305);
      cw(16'h0208);
      cw(16'h0208);
      check("fetch_ir",    32'(ir), 32'h03);
      check("fetch_pc",    32'(pc), 32'h01);
      check("fetch_reads", 32'(rd_cnt), 32'd1);
      check("fetch_raddr", 32'(last_raddr), 32'h00);
      cw(16'h0400);
      check("fetch_br",    32'(br), 32'h0305);

      // Store
      acc_value = 16'h0010; cw(16'h0800);
      cw(16'h0040);
      acc_value = 16'hBEEF; cw(16'h0800);
      cw(16'h0100);
      check("st_writes", 32'(wr_cnt), 32'd1);
      check("st_waddr",  32'(last_waddr), 32'h10);
      check("st_wdata",  32'(last_wdata), 32'hBEEF);
      check("st_mem",    32'(mem_arr[8'h10]), 32'hBEEF);
      check("st_addr",   32'(bus.mem_addr), 32'h10);

      // Jump and wrap
      acc_value = 16'h00FF; cw(16'h0800);
      cw(16'h0010);
      check("jmp_ff",   32'(pc), 32'hFF);
      cw(16'h0008);
      check("wrap_pc",  32'(pc), 32'h00);
      acc_value = 16'h002A; cw(16'h0800);
      cw(16'h0018);
      check("jmp_prio", 32'(pc), 32'h2A);

      // ACC load beats the read capture
      acc_value = 16'h0020; cw(16'h0800);
      cw(16'h0040);
      acc_value = 16'h5678;
      cyc(16'h0080);
      cyc(16'h0880);
      cyc(16'h0000);
      cw(16'h0000);
      check("cf_mbr",   32'(bus.mem_wdata), 32'h5678);
      check("cf_reads", 32'(rd_cnt), 32'd2);

      // Read and write together: one write only
      cw(16'h0180);
      cw(16'h0000);
      check("rw_writes", 32'(wr_cnt), 32'd2);
      check("rw_reads",  32'(rd_cnt), 32'd2);
      check("rw_mem",    32'(mem_arr[8'h20]), 32'h5678);
      check("rw_mbr",    32'(bus.mem_wdata), 32'h5678);

      // IR sources the MBR value from before the read capture
      acc_value = 16'hAB00; cw(16'h0800);
      cyc(16'h0080);
      cyc(16'h0280);
      cyc(16'h0000);
      check("src_ir",  32'(ir), 32'hAB);
      check("src_mbr", 32'(bus.mem_wdata), 32'h5678);

      // MAR takes pre-increment PC
      cw(16'h0028);
      check("src_mar", 32'(bus.mem_addr), 32'h2A);
      check("src_pc",  32'(pc), 32'h2B);

      // HALT hold, then a long-held increment
      en_snap = en_cnt;
      ctrl = 16'h0000;
      repeat (50) @(negedge clk);
      check("halt_en", 32'(en_cnt - en_snap), 32'd0);
      ctrl = 16'h0008;
      repeat (40) @(negedge clk);
      check("halt_pc",  32'(pc), 32'h2C);
      check("halt_mar", 32'(bus.mem_addr), 32'h2A);
      check("halt_mbr", 32'(bus.mem_wdata), 32'h5678);
      check("halt_ir",  32'(ir), 32'hAB);
      check("halt_br",  32'(br), 32'h0305);
`ifdef DP_TRACE_EN
      check("trace_cnt", 32'(trc_cnt), 32'd2);
      check("trace_pc",  32'(trc_last), 32'h20);
`endif

      // Reset while a read is pending
      cw(16'h0000);
      cyc(16'h0080);
      rst_n = 1'b0;
      ctrl = 16'h0000;
      repeat (2) @(negedge clk);
      check("mrst_pc",  32'(pc), 32'h00);
      check("mrst_mbr", 32'(bus.mem_wdata), 32'h0000);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("mrst_nocap", 32'(bus.mem_wdata), 32'h0000);
      check("mrst_ir",    32'(ir), 32'h00);
      check("mrst_br",    32'(br), 32'h0000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/cpu_datapath_regs.md
Name: cpu_datapath_regs

Overview:
- Register-transfer datapath stage directly downstream of the microprogrammed control unit.
- Consumes the 16-bit control word and executes its transfer micro-ops on PC, MAR, MBR, IR and BR.
- Drives the synchronous main memory, supplies IR to the control unit and BR to the ALU/ACC block.
- Each control word is held for two clock cycles, so every micro-op bit acts once, on its rising edge only.

Parameters:
- DATA_W, 16: memory word, MBR and BR width. Instruction format: [15:8] opcode, [7:0] operand address.
- ADDR_W, 8: PC and MAR width. ADDR_W <= DATA_W-8 is required.
- PC_RESET, 0: PC value loaded at reset.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ctrl  in  16  control word. [2:0] sequencing (ignored here), [11:3] transfer micro-ops, [15:12] ALU op (ignored here).
- acc_value  in  DATA_W  current ACC contents, from the ALU/ACC block
- mem_rdata  in  DATA_W  synchronous memory read data, valid 1 cycle after mem_en
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address; always equals MAR
- mem_wdata  out  DATA_W  memory write data; always equals MBR
- ir  out  8  instruction register, to the CU mapping logic
- br  out  DATA_W  buffer register, to the ALU
- pc  out  ADDR_W  program counter, for debug display

Behaviour:
- Reset (asynchronous, active-low):
  - pc=PC_RESET; MAR, MBR, IR, BR all 0.
  - mem_en=0, mem_we=0.
  - Read-pending flag cleared; edge-detect history register cleared.
- Edge detect:
  - prev <= ctrl[11:3] every cycle.
  - fire[k] = ctrl[k] & ~prev[k].
  - A bit held across consecutive cycles, or across two consecutive control words, fires once.
- Micro-op map, acting on the clock edge after the fire cycle:
  - bit3: PC<=PC+1. Wraps modulo 2^ADDR_W, so FF -> 00.
  - bit4: PC<=MBR[ADDR_W-1:0] (jump).
  - bit5: MAR<=PC.
  - bit6: MAR<=MBR[ADDR_W-1:0].
  - bit7: memory read. mem_en=1 for exactly 1 cycle (the fire cycle, combinational from fire). Sets read-pending. On the next edge MBR<=mem_rdata and pending clears.
  - bit8: memory write. mem_en=1 and mem_we=1 for exactly 1 cycle, with address MAR and data MBR as they stood before the edge.
  - bit9: IR<=MBR[DATA_W-1:DATA_W-8].
  - bit10: BR<=MBR.
  - bit11: MBR<=acc_value.
- Conflict priority for simultaneous fires:
  - PC: bit4 over bit3.
  - MAR: bit6 over bit5.
  - MBR: bit11 over a pending read capture; the read data is dropped and pending clears.
  - bit7 and bit8 together: one write access (mem_en=1, mem_we=1). The read is ignored and pending is not set.
- Same-cycle data sourcing: every source is the pre-edge register value.
  - Example: bit5 with bit3 gives MAR = old PC.
  - Example: bit9 in the cycle MBR captures read data gives IR from the old MBR.
- Idle and HALT (ctrl[11:3]=0, or held constant): all registers hold; mem_en=0.
- Reset mid-read: pending is dropped and MBR stays 0 after reset.
- Latency:
  - Register transfers: 1 cycle.
  - Memory read into MBR: 2 cycles from the ctrl bit7 rising edge.

Optional Feature:
- Macro: DP_TRACE_EN.
- When defined, adds two outputs:
  - trace_valid (1): 1-cycle pulse on the edge where IR is loaded.
  - trace_pc (ADDR_W): MAR value at that edge, i.e. the fetched instruction's address.
  - Both reset to 0.
- When undefined, neither port exists and behaviour is otherwise identical.

Test Plan:
- Reset: assert rst_n=0 mid-operation -> pc=00, mar=0, mbr=0, ir=00, br=0000, mem_en=0; no MBR capture after release.
- Fetch: mem[00]=16'h0305; sequence ctrl bits 5, 7, (3 with 9), each held 2 cycles -> one read at addr 00, MBR=0305, IR=03, PC=01 (incremented once, not twice).
- Store: ACC=16'hBEEF, MAR=10 via bit6 with MBR[7:0]=10; bits 11 then 8 -> exactly one write cycle, mem_addr=10, mem_wdata=BEEF, mem_we high 1 cycle.
- Jump/wrap: PC=FF plus bit3 -> PC=00. Bits 3 and 4 together with MBR[7:0]=2A -> PC=2A.
- Conflict: bit11 fires the cycle after bit7 with mem_rdata=1234, ACC=5678 -> MBR=5678 and pending cleared. Bits 7 and 8 together -> single write, MBR unchanged afterwards.
- HALT hold: ctrl held at 16'h0000 for 50 cycles, then a control word with bit3 held 40 cycles -> registers stable throughout, PC increments exactly once.
